// File: rtl/fp8_dot_sched_pkg.sv
// Shared types and FP8 (E4M3) constants for the dot-product sequencer and its benches.
package fp8_dot_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ISSUE,
    ST_WAIT,
    ST_RESULT
  } state_e;

  localparam logic [7:0] FP8_ZERO = 8'h00;
  localparam logic [7:0] FP8_ONE  = 8'h38;
  localparam logic [7:0] FP8_TWO  = 8'h40;

  // Result register contents; err qualifies data (data is FP8_ZERO when err is set).
  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } res_t;

endpackage

// File: rtl/fp8_dot_sched_if.sv
// Command / operand / MAC / result bundle for fp8_dot_sched.
interface fp8_dot_sched_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             mac_start;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic             mac_done;
  logic [7:0]       mac_acc;
  logic             mac_clr_n;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_err;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_len, in_valid, in_a, in_b, mac_done, mac_acc, res_ready,
    output cmd_ready, in_ready, mac_start, mac_a, mac_b, mac_clr_n,
           res_valid, res_data, res_err, busy
  );

  modport master (
    output cmd_valid, cmd_len, in_valid, in_a, in_b, mac_done, mac_acc, res_ready,
    input  cmd_ready, in_ready, mac_start, mac_a, mac_b, mac_clr_n,
           res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/fp8_dot_sched.sv
// Sequencer for one FP8 MAC: clears the accumulator, streams N operand pairs one at a
// time and returns the final accumulator, with a per-operation watchdog.
module fp8_dot_sched
  import fp8_dot_sched_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 7
) (
  input logic            clk,
  input logic            rst_n,
  fp8_dot_sched_if.slave bus
);

  state_e           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic             mac_start_q;
  logic [7:0]       mac_a_q;
  logic [7:0]       mac_b_q;
  logic             mac_clr_n_q;
  logic             res_valid_q;
  res_t             res_q;

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.in_ready  = (state == ST_ISSUE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.mac_start = mac_start_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_clr_n = mac_clr_n_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_q.data;
  assign bus.res_err   = res_q.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      cnt         <= '0;
      tmo         <= '0;
      mac_start_q <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_clr_n_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      // Pulses default off; clear is driven low only for the single CLEAR cycle.
      mac_start_q <= 1'b0;
      mac_clr_n_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            len_q <= bus.cmd_len;
            cnt   <= '0;
            if (bus.cmd_len == '0) begin
              state       <= ST_RESULT;
              res_valid_q <= 1'b1;
              res_q       <= '{err: 1'b0, data: FP8_ZERO};
            end else begin
              state       <= ST_CLEAR;
              mac_clr_n_q <= 1'b0;
            end
          end
        end
        ST_CLEAR: state <= ST_ISSUE;
        ST_ISSUE: begin
          if (bus.in_valid) begin
            mac_a_q     <= bus.in_a;
            mac_b_q     <= bus.in_b;
            mac_start_q <= 1'b1;
            cnt         <= cnt + LEN_W'(1);
            tmo         <= '0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A done arriving on the watchdog's last cycle still counts as success.
          if (bus.mac_done) begin
            if (cnt == len_q) begin
              state       <= ST_RESULT;
              res_valid_q <= 1'b1;
              res_q       <= '{err: 1'b0, data: bus.mac_acc};
            end else begin
              state <= ST_ISSUE;
            end
          end else if (tmo == TMO_W'(TIMEOUT)) begin
            state       <= ST_RESULT;
            res_valid_q <= 1'b1;
            res_q       <= '{err: 1'b1, data: FP8_ZERO};
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_dot_sched.sv
// Randomized self-checking bench for fp8_dot_sched with a behavioural FP8 MAC stub.
module tb_fp8_dot_sched;
  import fp8_dot_sched_pkg::*;

  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 64;
  localparam int TMO_W   = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp8_dot_sched_if #(.LEN_W(LEN_W)) bus ();

  fp8_dot_sched #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int clrs   = 0;
  int mac_lat = 2;
  bit mac_stall = 1'b0;
  logic [7:0] opa [256];
  logic [7:0] opb [256];

  // ---------------- FP8 E4M3 reference arithmetic ----------------
  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp8_dec(input logic [7:0] x);
    real v;
    if (x[6:3] == 4'd0) v = (real'(x[2:0]) / 8.0) * pow2(-6);
    else                v = (1.0 + real'(x[2:0]) / 8.0) * pow2(int'(x[6:3]) - 7);
    return x[7] ? -v : v;
  endfunction

  function automatic logic [7:0] fp8_enc(input real r);
    real a;
    int  e, be, m;
    logic s;
    if (r == 0.0) return 8'h00;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    be = e + 7;
    if (be < 1)  return {s, 7'h00};
    if (be > 15) return {s, 4'hF, 3'b110};
    m = $rtoi((a - 1.0) * 8.0);
    if (be == 15 && m == 7) m = 6;
    return {s, 4'(be), 3'(m)};
  endfunction

  function automatic logic [7:0] fp8_mac_ref(input logic [7:0] acc, a, b);
    return fp8_enc(fp8_dec(acc) + fp8_dec(a) * fp8_dec(b));
  endfunction

  function automatic logic [7:0] rand_op();
    return {1'($urandom_range(0, 1)), 4'($urandom_range(5, 8)), 3'($urandom)};
  endfunction

  // ---------------- MAC stub (reset pin = mac_clr_n & rst_n) ----------------
  bit mac_busy;
  int lat_cnt;
  logic [7:0] acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 8'h00; mac_busy <= 1'b0; bus.mac_done <= 1'b0; bus.mac_acc <= 8'h00; lat_cnt <= 0;
    end else if (!bus.mac_clr_n) begin
      acc <= 8'h00; mac_busy <= 1'b0; bus.mac_done <= 1'b0; bus.mac_acc <= 8'h00;
    end else begin
      bus.mac_done <= 1'b0;
      if (bus.mac_start) begin
        mac_busy <= 1'b1;
        lat_cnt  <= mac_lat;
      end else if (mac_busy && !mac_stall) begin
        if (lat_cnt <= 1) begin
          acc          <= fp8_mac_ref(acc, bus.mac_a, bus.mac_b);
          bus.mac_acc  <= fp8_mac_ref(acc, bus.mac_a, bus.mac_b);
          bus.mac_done <= 1'b1;
          mac_busy     <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.mac_start === 1'b1) starts++;
      if (bus.mac_clr_n === 1'b0) clrs++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue_cmd(input int n);
    int k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LEN_W'(n);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, b, input int gmax);
    int k = 0;
    repeat ($urandom_range(0, gmax)) @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    while (bus.in_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Runs one command over opa/opb[0..n-1] and checks result, hold stability and MAC activity.
  task automatic run_cmd(input string tag, input int n, input int gmax, input int hold,
                         output int lat);
    logic [7:0] exp = FP8_ZERO;
    int k = 0;
    for (int i = 0; i < n; i++) exp = fp8_mac_ref(exp, opa[i], opb[i]);
    @(negedge clk);
    starts = 0; clrs = 0;
    issue_cmd(n);
    for (int i = 0; i < n; i++) send_op(opa[i], opb[i], gmax);
    while (bus.res_valid !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    lat = k;
    checks++;
    if (bus.res_valid !== 1'b1) $display("FAIL %s res_valid got %b want 1", tag, bus.res_valid);
    checks++;
    if (bus.res_data !== exp) $display("FAIL %s res_data got %h want %h", tag, bus.res_data, exp);
    if (bus.res_data !== exp) errors++;
    if (bus.res_valid !== 1'b1) errors++;
    checks++;
    if (bus.res_err !== 1'b0) begin
      $display("FAIL %s res_err got %b want 0", tag, bus.res_err); errors++;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp) begin
        $display("FAIL %s hold%0d valid/data got %b/%h want 1/%h", tag, h, bus.res_valid,
                 bus.res_data, exp);
        errors++;
      end
    end
    checks++;
    if (starts != n || clrs != (n > 0 ? 1 : 0)) begin
      $display("FAIL %s starts/clears got %0d/%0d want %0d/%0d", tag, starts, clrs, n,
               (n > 0 ? 1 : 0));
      errors++;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      $display("FAIL %s post-accept busy/valid/cmd_ready got %b/%b/%b want 0/0/1", tag,
               bus.busy, bus.res_valid, bus.cmd_ready);
      errors++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.mac_start !== 1'b0 || bus.mac_a !== 8'h00 || bus.mac_b !== 8'h00 ||
        bus.mac_clr_n !== 1'b1) begin
      $display("FAIL %s mac start/a/b/clr_n got %b/%h/%h/%b want 0/00/00/1", tag, bus.mac_start,
               bus.mac_a, bus.mac_b, bus.mac_clr_n);
      errors++;
    end
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== 8'h00 || bus.res_err !== 1'b0) begin
      $display("FAIL %s res valid/data/err got %b/%h/%b want 0/00/0", tag, bus.res_valid,
               bus.res_data, bus.res_err);
      errors++;
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.in_ready !== 1'b0) begin
      $display("FAIL %s busy/cmd_ready/in_ready got %b/%b/%b want 0/1/0", tag, bus.busy,
               bus.cmd_ready, bus.in_ready);
      errors++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    int lat;
    run_cmd("zero_len", 0, 0, 2, lat);
    checks++;
    if (lat != 0) begin
      $display("FAIL zero_len latency got %0d want 0", lat); errors++;
    end
  endtask

  task automatic test_single();
    int lat;
    opa[0] = FP8_ONE; opb[0] = FP8_TWO;
    run_cmd("single", 1, 0, 0, lat);
  endtask

  task automatic test_gaps();
    int lat;
    for (int i = 0; i < 4; i++) begin opa[i] = FP8_ONE; opb[i] = FP8_ONE; end
    run_cmd("gaps_n4", 4, 3, 0, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < 2; i++) begin opa[i] = rand_op(); opb[i] = rand_op(); end
    run_cmd("b2b_first", 2, 1, 5, lat);
    for (int i = 0; i < 2; i++) begin opa[i] = rand_op(); opb[i] = rand_op(); end
    run_cmd("b2b_second", 2, 0, 5, lat);
  endtask

  task automatic test_timeout();
    int k = 0;
    int c = 0;
    @(negedge clk);
    mac_stall = 1'b1; starts = 0;
    issue_cmd(3);
    bus.in_valid = 1'b1; bus.in_a = FP8_ONE; bus.in_b = FP8_ONE;
    while (bus.in_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    checks++;
    if (bus.mac_start !== 1'b1) begin
      $display("FAIL timeout mac_start got %b want 1", bus.mac_start); errors++;
    end
    // in_valid stays high: the remaining operands are on offer but must not be taken.
    while (bus.res_valid !== 1'b1 && c < TIMEOUT + 20) begin @(negedge clk); c++; end
    checks++;
    if (c != TIMEOUT + 1) begin
      $display("FAIL timeout cycles got %0d want %0d", c, TIMEOUT + 1); errors++;
    end
    checks++;
    if (bus.res_err !== 1'b1 || bus.res_data !== FP8_ZERO) begin
      $display("FAIL timeout err/data got %b/%h want 1/00", bus.res_err, bus.res_data); errors++;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || starts != 1 || bus.in_ready !== 1'b0) begin
      $display("FAIL timeout idle busy/starts/in_ready got %b/%0d/%b want 0/1/0", bus.busy,
               starts, bus.in_ready);
      errors++;
    end
    bus.in_valid = 1'b0;
    mac_stall = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    @(negedge clk);
    mac_lat = 20;
    issue_cmd(2);
    send_op(FP8_TWO, FP8_TWO, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.mac_a !== FP8_TWO) begin
      $display("FAIL rst_mid busy/mac_a got %b/%h want 1/%h", bus.busy, bus.mac_a, FP8_TWO);
      errors++;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      $display("FAIL rst_mid stray res_valid got %b want 0", bus.res_valid); errors++;
    end
    mac_lat = 2;
    opa[0] = FP8_ONE; opb[0] = FP8_TWO;
    run_cmd("rst_recover", 1, 0, 0, lat);
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(1, 6);
      mac_lat = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin opa[i] = rand_op(); opb[i] = rand_op(); end
      run_cmd($sformatf("random%0d", t), n, 3, $urandom_range(0, 3), lat);
    end
    mac_lat = 2;
  endtask

  task automatic test_max_len();
    int lat;
    mac_lat = 1;
    for (int i = 0; i < 255; i++) begin opa[i] = rand_op(); opb[i] = rand_op(); end
    run_cmd("max_len", 255, 0, 0, lat);
    mac_lat = 2;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0;
    bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00;
    bus.res_ready = 1'b0;
    test_reset();
    test_zero_len();
    test_single();
    test_gaps();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_max_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not complete within time limit");
    $fatal(1, "global timeout");
  end

endmodule
